// File: rtl/fetch_control_pkg.sv
// Shared fetch-stage definitions: FSM encodings, instruction width, NOP word
// and the PC legality test used by next-PC selection.
package fetch_control_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // A PC is legal when word-aligned and inside the instruction memory.
    function automatic logic pc_ok(input logic [XLEN-1:0] pc, input int unsigned words);
        logic [XLEN-1:0] word_idx;
        word_idx = {2'b00, pc[XLEN-1:2]};
        return (pc[1:0] == 2'b00) && (word_idx < words);
    endfunction

endpackage

// File: rtl/fetch_control_pc_sel.sv
// Combinational next-PC selection (redirect > stall > sequential) and the
// legality check of the PC that would be loaded.
module fetch_pc_sel
    import fetch_control_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic [XLEN-1:0] PC,
    input  logic            Redirect,
    input  logic [XLEN-1:0] Target,
    input  logic            Stall_F,
    output logic [XLEN-1:0] Next_PC,
    output logic            PC_Fault
);

    always_comb begin
        Next_PC = PC + 32'd4;
        if (Redirect) begin
            Next_PC = Target;
        end else if (Stall_F) begin
            Next_PC = PC;
        end
        PC_Fault = !pc_ok(Next_PC, MEM_WORDS);
    end

endmodule

// File: rtl/fetch_control.sv
// Instruction fetch control: PC register, IF/ID register and the
// BOOT/RUN/HALTED/FAULT sequencing. Instruction memory is external.
module fetch_control
    import fetch_control_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall_F,
    input  logic        Redirect,
    input  logic [31:0] Target,
    input  logic        Flush_D,
    input  logic        Halt,
    input  logic [31:0] IM_Instr,
    output logic [31:0] IM_Addr,
    output logic [31:0] Instr_D,
    output logic [31:0] PCPlus4_D,
    output logic        Valid_D,
    output logic        Fault,
    output logic [1:0]  State
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           ifid_q, ifid_d;

    logic [XLEN-1:0] pc_next;
    logic            pc_fault;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    fetch_pc_sel #(
        .MEM_WORDS(MEM_WORDS)
    ) u_pc_sel (
        .PC      (pc_q),
        .Redirect(Redirect),
        .Target  (Target),
        .Stall_F (Stall_F),
        .Next_PC (pc_next),
        .PC_Fault(pc_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ifid_q  <= '{instr: NOP, pc_plus4: '0, valid: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        case (state_q)
            ST_BOOT: begin
                state_d      = ST_RUN;
                ifid_d.valid = 1'b0;
            end
            ST_RUN: begin
                // A faulting load outranks Halt; the PC keeps its last legal value.
                if (pc_fault) begin
                    state_d      = ST_FAULT;
                    ifid_d.valid = 1'b0;
                end else if (Halt) begin
                    state_d      = ST_HALTED;
                    ifid_d.valid = 1'b0;
                end else begin
                    pc_d = pc_next;
                    if (Flush_D) begin
                        ifid_d.valid = 1'b0;
                        ifid_d.instr = NOP;
                    end else if (Redirect || !Stall_F) begin
                        ifid_d = '{instr: IM_Instr, pc_plus4: pc_plus4, valid: 1'b1};
                    end
                end
            end
            ST_HALTED: begin
            end
            ST_FAULT: begin
            end
        endcase
    end

    assign IM_Addr   = pc_q;
    assign Instr_D   = ifid_q.instr;
    assign PCPlus4_D = ifid_q.pc_plus4;
    assign Valid_D   = ifid_q.valid;
    assign Fault     = (state_q == ST_FAULT);
    assign State     = state_q;

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: a cycle model predicts the full
// output vector each cycle, plus directed checks of the key scenarios.
module tb_fetch_control;

    localparam int W = 100;

    logic        clk;
    logic        rst;
    logic        Stall_F;
    logic        Redirect;
    logic [31:0] Target;
    logic        Flush_D;
    logic        Halt;
    logic [31:0] IM_Instr;
    logic [31:0] IM_Addr;
    logic [31:0] Instr_D;
    logic [31:0] PCPlus4_D;
    logic        Valid_D;
    logic        Fault;
    logic [1:0]  State;

    logic [31:0] imem [64];

    int n_checks;
    int n_errors;

    logic [W-1:0] exp_q[$];

    // reference model state
    logic [1:0]  m_state;
    logic        m_fault;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic        m_valid;

    fetch_control #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Stall_F  (Stall_F),
        .Redirect (Redirect),
        .Target   (Target),
        .Flush_D  (Flush_D),
        .Halt     (Halt),
        .IM_Instr (IM_Instr),
        .IM_Addr  (IM_Addr),
        .Instr_D  (Instr_D),
        .PCPlus4_D(PCPlus4_D),
        .Valid_D  (Valid_D),
        .Fault    (Fault),
        .State    (State)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign IM_Instr = (IM_Addr[31:8] == 24'd0) ? imem[IM_Addr[7:2]] : 32'hDEAD_BEEF;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got no end, required end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [1:0] st, input logic flt, input logic vld,
                                          input logic [31:0] pc, input logic [31:0] ins,
                                          input logic [31:0] p4);
        return {st, flt, vld, pc, ins, p4};
    endfunction

    // one-cycle behavioural model of the fetch stage
    task automatic model_step(input logic st, input logic rd, input logic [31:0] tg,
                              input logic fl, input logic hl, input logic rs);
        logic [31:0] cand;
        logic        bad;
        if (rs) begin
            m_state = 2'd0; m_fault = 1'b0; m_pc = 32'h0;
            m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        end else if (m_state == 2'd0) begin
            m_state = 2'd1;
            m_valid = 1'b0;
        end else if (m_state == 2'd1) begin
            cand = rd ? tg : (st ? m_pc : m_pc + 32'd4);
            bad  = (cand % 4 != 0) || (cand / 4 >= 64);
            if (bad) begin
                m_state = 2'd3; m_fault = 1'b1; m_valid = 1'b0;
            end else if (hl) begin
                m_state = 2'd2; m_valid = 1'b0;
            end else begin
                if (fl) begin
                    m_valid = 1'b0; m_instr = 32'h0;
                end else if (rd || !st) begin
                    m_instr = imem[m_pc[7:2]];
                    m_pcp4  = m_pc + 32'd4;
                    m_valid = 1'b1;
                end
                m_pc = cand;
            end
        end
    endtask

    // driver: apply inputs on the falling edge, compare just after the rising edge
    task automatic step(input logic st, input logic rd, input logic [31:0] tg,
                        input logic fl, input logic hl, input logic rs);
        logic [W-1:0] exp;
        @(negedge clk);
        Stall_F = st; Redirect = rd; Target = tg; Flush_D = fl; Halt = hl; rst = rs;
        model_step(st, rd, tg, fl, hl, rs);
        exp_q.push_back(pack(m_state, m_fault, m_valid, m_pc, m_instr, m_pcp4));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check("cycle", pack(State, Fault, Valid_D, IM_Addr, Instr_D, PCPlus4_D), exp);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_step(input logic allow_halt);
        logic [31:0] tg;
        logic        rd;
        tg = 32'($urandom_range(0, 63)) << 2;
        rd = ($urandom_range(0, 5) == 0);
        if (m_pc >= 32'hF0) begin
            rd = 1'b1;
            tg = 32'h40;
        end
        step($urandom_range(0, 3) == 0, rd, tg, $urandom_range(0, 7) == 0,
             allow_halt && ($urandom_range(0, 5) == 0), 1'b0);
    endtask

    initial begin
        logic [31:0] held_pc;
        int          guard;

        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        rst = 1'b1; Stall_F = 1'b0; Redirect = 1'b0; Target = 32'h0; Flush_D = 1'b0; Halt = 1'b0;
        m_state = 2'd0; m_fault = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;

        // reset for two cycles with noisy inputs: reset must win
        step(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_state", State, 2'd0);
        check("rst_valid", Valid_D, 1'b0);
        check("rst_pc", IM_Addr, 32'h0);
        check("rst_fault", Fault, 1'b0);
        check("rst_instr", Instr_D, 32'h0);
        check("rst_pcp4", PCPlus4_D, 32'h0);

        // boot lasts one cycle, then sequential fetch
        idle();
        check("boot_exit_state", State, 2'd1);
        check("boot_no_fetch_pc", IM_Addr, 32'h0);
        check("boot_no_fetch_valid", Valid_D, 1'b0);
        idle();
        check("seq_pc4", IM_Addr, 32'h4);
        check("seq_valid", Valid_D, 1'b1);
        check("seq_instr0", Instr_D, imem[0]);
        check("seq_pcp4", PCPlus4_D, 32'h4);
        idle();
        check("seq_pc8", IM_Addr, 32'h8);
        idle();
        idle();
        check("at_0x10", IM_Addr, 32'h10);

        // stall three cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            check("stall_pc", IM_Addr, 32'h10);
            check("stall_instr", Instr_D, imem[3]);
        end
        idle();
        check("stall_release_pc", IM_Addr, 32'h14);
        check("stall_release_instr", Instr_D, imem[4]);

        // redirect beats stall; redirect still loads IF/ID from the current fetch
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        check("redir_pc", IM_Addr, 32'h20);
        check("redir_ifid_instr", Instr_D, imem[5]);
        check("redir_ifid_pcp4", PCPlus4_D, 32'h18);
        step(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
        check("flush_pc", IM_Addr, 32'h30);
        check("flush_valid", Valid_D, 1'b0);
        check("flush_instr", Instr_D, 32'h0);
        check("flush_pcp4_kept", PCPlus4_D, 32'h18);

        // random run without halts
        for (int i = 0; i < 40; i++) rand_step(1'b0);

        // misaligned redirect faults and sticks
        held_pc = m_pc;
        step(1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        check("mis_state", State, 2'd3);
        check("mis_fault", Fault, 1'b1);
        check("mis_pc_held", IM_Addr, held_pc);
        check("mis_valid", Valid_D, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom_range(0, 63)) << 2,
                 $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
        end
        check("fault_sticky_state", State, 2'd3);
        check("fault_sticky_pc", IM_Addr, held_pc);

        // reset out of FAULT, then run sequentially to the last word
        step(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1);
        check("rst_from_fault_state", State, 2'd0);
        check("rst_from_fault_fault", Fault, 1'b0);
        check("rst_from_fault_valid", Valid_D, 1'b0);
        idle();
        guard = 0;
        while (m_pc != 32'hFC && guard < 100) begin
            idle();
            guard++;
        end
        check("reach_0xfc", IM_Addr, 32'hFC);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("oob_state", State, 2'd3);
        check("oob_fault", Fault, 1'b1);
        check("oob_pc_held", IM_Addr, 32'hFC);

        // halt at 0x08
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        idle();
        check("pre_halt_pc", IM_Addr, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("halt_state", State, 2'd2);
        check("halt_pc", IM_Addr, 32'h8);
        check("halt_valid", Valid_D, 1'b0);
        check("halt_no_fault", Fault, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(0, 1), 1'b1, 32'h22, $urandom_range(0, 1), 1'b0, 1'b0);
        end
        check("halted_frozen_pc", IM_Addr, 32'h8);
        check("halted_state_kept", State, 2'd2);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("halt_rst_state", State, 2'd0);
        check("halt_rst_pc", IM_Addr, 32'h0);
        idle();
        idle();
        check("restart_pc", IM_Addr, 32'h4);

        // random run with halts allowed
        for (int i = 0; i < 30; i++) rand_step(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
